ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Reader side of the ID/EX pipeline register: consumes ID_EX_* datapath and control outputs and executes the instruction.
- Performs operand forwarding, the 8-bit ALU operation and carry/zero flag update.
- Registers the result into the EX/MEM pipeline register, which is internal to this block.
- Sits between the ID_EX register and the memory stage; MEM/WB feeds back for forwarding.

Parameters:
- DATA_W, 8, datapath width.
- INSTR_W, 19, instruction width.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- flush  in  1  synchronous clear of the EX/MEM register; flags are untouched
- ID_EX_A, ID_EX_B  in  8 each  register-file operands
- ID_EX_instruction  in  19  instruction word
- ID_EX_mem_write, ID_EX_reg_write, ID_EX_alu_use_carry, ID_EX_alu_B_mux  in  1 each  control
- ID_EX_select_c, ID_EX_select_z, ID_EX_write_c, ID_EX_write_z  in  1 each  flag control
- ID_EX_alu_op  in  3  ALU operation
- ID_EX_reg_write_mux  in  2  write-back source select, passed through
- MEM_WB_reg_write  in  1  write-back stage writes a register
- MEM_WB_rd  in  3  write-back destination register
- MEM_WB_data  in  8  write-back data
- EX_MEM_alu_result  out  8  registered ALU result
- EX_MEM_store_data  out  8  registered forwarded B operand
- EX_MEM_instruction  out  19  registered instruction
- EX_MEM_mem_write, EX_MEM_reg_write  out  1 each  registered control
- EX_MEM_reg_write_mux  out  2  registered control
- carry_flag, zero_flag  out  1 each  architectural C and Z flags

Behaviour:
- Fields:
  - rd = instr[13:11], rs = instr[10:8], rt = instr[7:5].
  - imm8 = instr[7:0], zero-extended.
- Forwarding of operand A:
  - Use EX_MEM_alu_result if EX_MEM_reg_write, EX_MEM_reg_write_mux==2'b00 and EX_MEM rd==rs.
  - Otherwise use MEM_WB_data if MEM_WB_reg_write and MEM_WB_rd==rs.
  - Otherwise use ID_EX_A.
  - The EX/MEM source has priority when both match.
- Forwarding of operand B: same rules as A, comparing against rt.
- Register 0 is not special; forwarding applies to it.
- opB = imm8 when ID_EX_alu_B_mux=1, else forwarded B.
- EX_MEM_store_data always takes forwarded B, regardless of alu_B_mux.
- cin = ID_EX_alu_use_carry & carry_flag.
- alu_op encoding:
  - 000 ADD: {co,res} = A+opB+cin (9-bit).
  - 001 SUB: {co,res} = A-opB-cin (9-bit two's complement); co=1 means borrow.
  - 010 AND, 011 OR, 100 XOR: co=0.
  - 101 PASS B: res=opB, co=0.
  - 110 SHL1: res={A[6:0],cin}, co=A[7].
  - 111 SHR1: res={cin,A[7:1]}, co=A[0].
- zero = (res==0).
- Flags, registered at the clock edge:
  - If write_c: C <= select_c ? co : 0.
  - If write_z: Z <= select_z ? zero : 0.
  - Otherwise the flag holds its value.
  - A flag written by instruction N is visible to N+1 in the next cycle, so no flag hazard exists.
- EX/MEM register: one-cycle latency; captures res, forwarded B, instruction, mem_write, reg_write and reg_write_mux.
- reset:
  - All EX_MEM_* outputs go to 0 and carry_flag=zero_flag=0.
  - Takes effect on the next edge even mid-stream.
- flush:
  - All EX_MEM_* outputs go to 0 (bubble).
  - Flag writes in the same cycle still occur; the ID_EX flush upstream prevents squashed instructions.
  - reset overrides flush.
- An ID_EX bubble (all zero) executes ADD A+opB with no writes and reg_write=0, so it is harmless.

Decomposition:
- Shared package: alu_op constants (ALU_ADD..ALU_SHR), instruction field positions (RD_MSB/LSB, RS_*, RT_*, IMM_*), reg_write_mux code WB_ALU=2'b00.
- Sub-module alu8: purely combinational; inputs a, b, cin, op; outputs res, co, zero.
- Forwarding muxes, flags and the EX/MEM register live in ex_stage.

Test Plan:
- ADD, alu_op=000, A=0xF0, B=0x20, write_c=write_z=1, select_c=select_z=1 -> next cycle EX_MEM_alu_result=0x10, carry_flag=1, zero_flag=0.
- ADDC with carry_flag=1, A=0x01, imm8=0x01, alu_B_mux=1, alu_use_carry=1 -> result 0x03.
  - Same stimulus with alu_use_carry=0 -> result 0x02.
- SUB, A=0x05, B=0x05 -> result 0x00, Z=1, C=0.
  - Then SUB, A=0x00, B=0x01 -> result 0xFF, C=1 (borrow).
- Back-to-back dependency:
  - I1 writes r3=0x11; I2 has rs=r3 with stale ID_EX_A=0x00 -> I2 uses 0x11.
  - MEM_WB also matching r3 with 0x22 -> EX/MEM value 0x11 wins.
- flush asserted during an ADD with write_c=1 -> EX_MEM_* all 0 next cycle, carry_flag still updated.
  - reset during that same cycle -> everything 0.
- SHL1 with A=0x81, cin=1 -> result 0x03, C=1.
  - write_c=1, select_c=0 -> C cleared, result unchanged.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg
// Shared constants for the execute stage: ALU operation codes, instruction
// field positions and the write-back source code that marks an ALU result.
// No ports; imported by ex_stage and alu8.

package ex_stage_pkg;

    localparam int DATA_W  = 8;
    localparam int INSTR_W = 19;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_PSB = 3'b101;
    localparam logic [2:0] ALU_SHL = 3'b110;
    localparam logic [2:0] ALU_SHR = 3'b111;

    localparam int RD_MSB  = 13;
    localparam int RD_LSB  = 11;
    localparam int RS_MSB  = 10;
    localparam int RS_LSB  = 8;
    localparam int RT_MSB  = 7;
    localparam int RT_LSB  = 5;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    localparam logic [1:0] WB_ALU = 2'b00;

endpackage

// File: rtl/ex_stage_alu8.sv
// alu8
// Purely combinational 8-bit ALU.
// Ports:
//   a, b  : operands
//   cin   : carry/borrow in (also the bit shifted in by SHL1/SHR1)
//   op    : operation code (ALU_* in ex_stage_pkg)
//   res   : result
//   co    : carry out (borrow for SUB, shifted-out bit for shifts)
//   zero  : res == 0

module alu8
    import ex_stage_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    input  logic [2:0] op,
    output logic [7:0] res,
    output logic       co,
    output logic       zero
);

    logic [8:0] sum;
    logic [8:0] diff;

    // 9-bit arithmetic so bit 8 carries the carry (ADD) or borrow (SUB).
    assign sum  = {1'b0, a} + {1'b0, b} + {8'b0, cin};
    assign diff = {1'b0, a} - {1'b0, b} - {8'b0, cin};

    always_comb begin
        res = 8'h00;
        co  = 1'b0;
        case (op)
            ALU_ADD: {co, res} = sum;
            ALU_SUB: {co, res} = diff;
            ALU_AND: res = a & b;
            ALU_OR:  res = a | b;
            ALU_XOR: res = a ^ b;
            ALU_PSB: res = b;
            ALU_SHL: begin
                res = {a[6:0], cin};
                co  = a[7];
            end
            ALU_SHR: begin
                res = {cin, a[7:1]};
                co  = a[0];
            end
            default: begin
                res = 8'h00;
                co  = 1'b0;
            end
        endcase
    end

    assign zero = (res == 8'h00);

endmodule

// File: rtl/ex_stage.sv
// ex_stage
// Execute stage: forwards operands from EX/MEM and MEM/WB, runs the 8-bit
// ALU, updates the C/Z flags and registers the result into the EX/MEM
// pipeline register held inside this block.
// Ports:
//   clk, reset            : clock (rising edge), synchronous active-high reset
//   flush                 : bubbles the EX/MEM register; flags are unaffected
//   ID_EX_*               : operands, instruction and control from ID/EX
//   MEM_WB_reg_write/rd/data : write-back stage, used as forwarding source
//   EX_MEM_*              : registered result, store data, instruction, control
//   carry_flag, zero_flag : architectural flags

module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int INSTR_W = 19
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic [DATA_W-1:0]  ID_EX_A,
    input  logic [DATA_W-1:0]  ID_EX_B,
    input  logic [INSTR_W-1:0] ID_EX_instruction,
    input  logic               ID_EX_mem_write,
    input  logic               ID_EX_reg_write,
    input  logic               ID_EX_alu_use_carry,
    input  logic               ID_EX_alu_B_mux,
    input  logic               ID_EX_select_c,
    input  logic               ID_EX_select_z,
    input  logic               ID_EX_write_c,
    input  logic               ID_EX_write_z,
    input  logic [2:0]         ID_EX_alu_op,
    input  logic [1:0]         ID_EX_reg_write_mux,
    input  logic               MEM_WB_reg_write,
    input  logic [2:0]         MEM_WB_rd,
    input  logic [DATA_W-1:0]  MEM_WB_data,
    output logic [DATA_W-1:0]  EX_MEM_alu_result,
    output logic [DATA_W-1:0]  EX_MEM_store_data,
    output logic [INSTR_W-1:0] EX_MEM_instruction,
    output logic               EX_MEM_mem_write,
    output logic               EX_MEM_reg_write,
    output logic [1:0]         EX_MEM_reg_write_mux,
    output logic               carry_flag,
    output logic               zero_flag
);

    logic [2:0]        rs;
    logic [2:0]        rt;
    logic [2:0]        ex_mem_rd;
    logic [7:0]        imm8;
    logic              ex_mem_fwd_ok;
    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;
    logic [DATA_W-1:0] op_b;
    logic              cin;
    logic [DATA_W-1:0] alu_res;
    logic              alu_co;
    logic              alu_zero;

    assign rs        = ID_EX_instruction[RS_MSB:RS_LSB];
    assign rt        = ID_EX_instruction[RT_MSB:RT_LSB];
    assign imm8      = ID_EX_instruction[IMM_MSB:IMM_LSB];
    assign ex_mem_rd = EX_MEM_instruction[RD_MSB:RD_LSB];

    // Only an ALU-sourced write-back has its value available in EX/MEM;
    // other sources (e.g. memory load) are not known until later.
    assign ex_mem_fwd_ok = EX_MEM_reg_write && (EX_MEM_reg_write_mux == WB_ALU);

    always_comb begin
        fwd_a = ID_EX_A;
        if (ex_mem_fwd_ok && (ex_mem_rd == rs))
            fwd_a = EX_MEM_alu_result;
        else if (MEM_WB_reg_write && (MEM_WB_rd == rs))
            fwd_a = MEM_WB_data;
    end

    always_comb begin
        fwd_b = ID_EX_B;
        if (ex_mem_fwd_ok && (ex_mem_rd == rt))
            fwd_b = EX_MEM_alu_result;
        else if (MEM_WB_reg_write && (MEM_WB_rd == rt))
            fwd_b = MEM_WB_data;
    end

    assign op_b = ID_EX_alu_B_mux ? {{(DATA_W-8){1'b0}}, imm8} : fwd_b;
    assign cin  = ID_EX_alu_use_carry & carry_flag;

    alu8 u_alu8 (
        .a    (fwd_a),
        .b    (op_b),
        .cin  (cin),
        .op   (ID_EX_alu_op),
        .res  (alu_res),
        .co   (alu_co),
        .zero (alu_zero)
    );

    // Flags ignore flush: squashing is handled by the ID/EX flush upstream.
    always_ff @(posedge clk) begin
        if (reset) begin
            carry_flag <= 1'b0;
            zero_flag  <= 1'b0;
        end else begin
            if (ID_EX_write_c)
                carry_flag <= ID_EX_select_c ? alu_co : 1'b0;
            if (ID_EX_write_z)
                zero_flag <= ID_EX_select_z ? alu_zero : 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            EX_MEM_alu_result    <= '0;
            EX_MEM_store_data    <= '0;
            EX_MEM_instruction   <= '0;
            EX_MEM_mem_write     <= 1'b0;
            EX_MEM_reg_write     <= 1'b0;
            EX_MEM_reg_write_mux <= 2'b00;
        end else begin
            EX_MEM_alu_result    <= alu_res;
            EX_MEM_store_data    <= fwd_b;
            EX_MEM_instruction   <= ID_EX_instruction;
            EX_MEM_mem_write     <= ID_EX_mem_write;
            EX_MEM_reg_write     <= ID_EX_reg_write;
            EX_MEM_reg_write_mux <= ID_EX_reg_write_mux;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;

    logic        clk;
    logic        reset;
    logic        flush;
    logic [7:0]  ID_EX_A;
    logic [7:0]  ID_EX_B;
    logic [18:0] ID_EX_instruction;
    logic        ID_EX_mem_write;
    logic        ID_EX_reg_write;
    logic        ID_EX_alu_use_carry;
    logic        ID_EX_alu_B_mux;
    logic        ID_EX_select_c;
    logic        ID_EX_select_z;
    logic        ID_EX_write_c;
    logic        ID_EX_write_z;
    logic [2:0]  ID_EX_alu_op;
    logic [1:0]  ID_EX_reg_write_mux;
    logic        MEM_WB_reg_write;
    logic [2:0]  MEM_WB_rd;
    logic [7:0]  MEM_WB_data;
    logic [7:0]  EX_MEM_alu_result;
    logic [7:0]  EX_MEM_store_data;
    logic [18:0] EX_MEM_instruction;
    logic        EX_MEM_mem_write;
    logic        EX_MEM_reg_write;
    logic [1:0]  EX_MEM_reg_write_mux;
    logic        carry_flag;
    logic        zero_flag;

    int n_cmp;
    int n_bad;

    ex_stage dut (
        .clk                  (clk),
        .reset                (reset),
        .flush                (flush),
        .ID_EX_A              (ID_EX_A),
        .ID_EX_B              (ID_EX_B),
        .ID_EX_instruction    (ID_EX_instruction),
        .ID_EX_mem_write      (ID_EX_mem_write),
        .ID_EX_reg_write      (ID_EX_reg_write),
        .ID_EX_alu_use_carry  (ID_EX_alu_use_carry),
        .ID_EX_alu_B_mux      (ID_EX_alu_B_mux),
        .ID_EX_select_c       (ID_EX_select_c),
        .ID_EX_select_z       (ID_EX_select_z),
        .ID_EX_write_c        (ID_EX_write_c),
        .ID_EX_write_z        (ID_EX_write_z),
        .ID_EX_alu_op         (ID_EX_alu_op),
        .ID_EX_reg_write_mux  (ID_EX_reg_write_mux),
        .MEM_WB_reg_write     (MEM_WB_reg_write),
        .MEM_WB_rd            (MEM_WB_rd),
        .MEM_WB_data          (MEM_WB_data),
        .EX_MEM_alu_result    (EX_MEM_alu_result),
        .EX_MEM_store_data    (EX_MEM_store_data),
        .EX_MEM_instruction   (EX_MEM_instruction),
        .EX_MEM_mem_write     (EX_MEM_mem_write),
        .EX_MEM_reg_write     (EX_MEM_reg_write),
        .EX_MEM_reg_write_mux (EX_MEM_reg_write_mux),
        .carry_flag           (carry_flag),
        .zero_flag            (zero_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        flush               = 1'b0;
        ID_EX_A             = 8'h00;
        ID_EX_B             = 8'h00;
        ID_EX_instruction   = 19'h0;
        ID_EX_mem_write     = 1'b0;
        ID_EX_reg_write     = 1'b0;
        ID_EX_alu_use_carry = 1'b0;
        ID_EX_alu_B_mux     = 1'b0;
        ID_EX_select_c      = 1'b0;
        ID_EX_select_z      = 1'b0;
        ID_EX_write_c       = 1'b0;
        ID_EX_write_z       = 1'b0;
        ID_EX_alu_op        = 3'b000;
        ID_EX_reg_write_mux = 2'b00;
        MEM_WB_reg_write    = 1'b0;
        MEM_WB_rd           = 3'd0;
        MEM_WB_data         = 8'h00;
    endtask

    // Advance one clock and sample just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ex_mem_zero(input string tag);
        check({tag, ".alu_result"}, {24'b0, EX_MEM_alu_result}, 32'h0);
        check({tag, ".store_data"}, {24'b0, EX_MEM_store_data}, 32'h0);
        check({tag, ".instruction"}, {13'b0, EX_MEM_instruction}, 32'h0);
        check({tag, ".mem_write"}, {31'b0, EX_MEM_mem_write}, 32'h0);
        check({tag, ".reg_write"}, {31'b0, EX_MEM_reg_write}, 32'h0);
        check({tag, ".reg_write_mux"}, {30'b0, EX_MEM_reg_write_mux}, 32'h0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        check_ex_mem_zero("reset");
        check("reset.C", {31'b0, carry_flag}, 32'h0);
        check("reset.Z", {31'b0, zero_flag}, 32'h0);
        reset = 1'b0;

        // ADD 0xF0 + 0x20 -> 0x10, carry out
        idle_inputs();
        ID_EX_A = 8'hF0; ID_EX_B = 8'h20; ID_EX_alu_op = 3'b000;
        ID_EX_write_c = 1'b1; ID_EX_select_c = 1'b1;
        ID_EX_write_z = 1'b1; ID_EX_select_z = 1'b1;
        step();
        check("add.res", {24'b0, EX_MEM_alu_result}, 32'h10);
        check("add.store", {24'b0, EX_MEM_store_data}, 32'h20);
        check("add.C", {31'b0, carry_flag}, 32'h1);
        check("add.Z", {31'b0, zero_flag}, 32'h0);

        // ADDC with immediate, C=1: 0x01 + 0x01 + 1; store data keeps B
        idle_inputs();
        ID_EX_A = 8'h01; ID_EX_B = 8'h55; ID_EX_instruction = 19'h00001;
        ID_EX_alu_B_mux = 1'b1; ID_EX_alu_use_carry = 1'b1;
        step();
        check("addc.res", {24'b0, EX_MEM_alu_result}, 32'h03);
        check("addc.store", {24'b0, EX_MEM_store_data}, 32'h55);
        check("addc.instr", {13'b0, EX_MEM_instruction}, 32'h00001);
        check("addc.C_hold", {31'b0, carry_flag}, 32'h1);

        ID_EX_alu_use_carry = 1'b0;
        step();
        check("addnc.res", {24'b0, EX_MEM_alu_result}, 32'h02);

        // SUB 5-5 -> 0, Z=1 C=0
        idle_inputs();
        ID_EX_A = 8'h05; ID_EX_B = 8'h05; ID_EX_alu_op = 3'b001;
        ID_EX_write_c = 1'b1; ID_EX_select_c = 1'b1;
        ID_EX_write_z = 1'b1; ID_EX_select_z = 1'b1;
        step();
        check("sub0.res", {24'b0, EX_MEM_alu_result}, 32'h00);
        check("sub0.Z", {31'b0, zero_flag}, 32'h1);
        check("sub0.C", {31'b0, carry_flag}, 32'h0);

        // SUB 0-1 -> 0xFF with borrow
        ID_EX_A = 8'h00; ID_EX_B = 8'h01;
        step();
        check("subb.res", {24'b0, EX_MEM_alu_result}, 32'hFF);
        check("subb.C", {31'b0, carry_flag}, 32'h1);
        check("subb.Z", {31'b0, zero_flag}, 32'h0);

        // I1: writes r3 = 0x11
        idle_inputs();
        ID_EX_A = 8'h11; ID_EX_instruction = 19'h01800;
        ID_EX_reg_write = 1'b1;
        step();
        check("i1.res", {24'b0, EX_MEM_alu_result}, 32'h11);
        check("i1.reg_write", {31'b0, EX_MEM_reg_write}, 32'h1);

        // I2: rs=r3 with stale A=0, B=1; also writes r3
        idle_inputs();
        ID_EX_instruction = 19'h01B00; ID_EX_B = 8'h01;
        ID_EX_reg_write = 1'b1;
        step();
        check("fwd_exmem_a.res", {24'b0, EX_MEM_alu_result}, 32'h12);

        // I3: rs=rt=r3, MEM_WB also r3=0x22 -> EX/MEM 0x12 wins on both
        idle_inputs();
        ID_EX_instruction = 19'h00360;
        MEM_WB_reg_write = 1'b1; MEM_WB_rd = 3'd3; MEM_WB_data = 8'h22;
        step();
        check("fwd_prio.res", {24'b0, EX_MEM_alu_result}, 32'h24);
        check("fwd_prio.store", {24'b0, EX_MEM_store_data}, 32'h12);

        // I4: only MEM_WB matches rs
        idle_inputs();
        ID_EX_instruction = 19'h00300; ID_EX_B = 8'h01;
        MEM_WB_reg_write = 1'b1; MEM_WB_rd = 3'd3; MEM_WB_data = 8'h22;
        step();
        check("fwd_memwb.res", {24'b0, EX_MEM_alu_result}, 32'h23);

        // I5: EX/MEM writes r0 from a non-ALU source -> no forward from it
        idle_inputs();
        ID_EX_A = 8'h40; ID_EX_reg_write = 1'b1; ID_EX_reg_write_mux = 2'b01;
        step();
        idle_inputs();
        ID_EX_A = 8'h07; ID_EX_B = 8'h01;
        step();
        check("fwd_nonalu.res", {24'b0, EX_MEM_alu_result}, 32'h08);

        // Flush during ADD 1+1 with C write: bubble, C 1->0
        idle_inputs();
        ID_EX_A = 8'h01; ID_EX_B = 8'h01; ID_EX_instruction = 19'h7FFFF;
        ID_EX_mem_write = 1'b1; ID_EX_reg_write = 1'b1; ID_EX_reg_write_mux = 2'b10;
        ID_EX_instruction = 19'h00000;
        ID_EX_write_c = 1'b1; ID_EX_select_c = 1'b1;
        flush = 1'b1;
        step();
        check_ex_mem_zero("flush");
        check("flush.C", {31'b0, carry_flag}, 32'h0);

        // Load EX/MEM with nonzero state, C=1
        idle_inputs();
        ID_EX_A = 8'h80; ID_EX_B = 8'h80; ID_EX_instruction = 19'h12345;
        ID_EX_mem_write = 1'b1;
        ID_EX_write_c = 1'b1; ID_EX_select_c = 1'b1;
        step();
        check("pre_rst.instr", {13'b0, EX_MEM_instruction}, 32'h12345);
        check("pre_rst.mem_write", {31'b0, EX_MEM_mem_write}, 32'h1);
        check("pre_rst.C", {31'b0, carry_flag}, 32'h1);

        // Reset together with flush and a C-setting ADD
        ID_EX_A = 8'h80; ID_EX_B = 8'hC0; ID_EX_reg_write = 1'b1;
        ID_EX_write_z = 1'b1; ID_EX_select_z = 1'b1;
        flush = 1'b1;
        reset = 1'b1;
        step();
        check_ex_mem_zero("rst_mid");
        check("rst_mid.C", {31'b0, carry_flag}, 32'h0);
        check("rst_mid.Z", {31'b0, zero_flag}, 32'h0);
        reset = 1'b0;

        // Set C=1 again, then SHL1 0x81 with cin=1
        idle_inputs();
        ID_EX_A = 8'h80; ID_EX_B = 8'h80;
        ID_EX_write_c = 1'b1; ID_EX_select_c = 1'b1;
        step();
        check("setc.C", {31'b0, carry_flag}, 32'h1);
        ID_EX_A = 8'h81; ID_EX_B = 8'h00; ID_EX_alu_op = 3'b110;
        ID_EX_alu_use_carry = 1'b1;
        step();
        check("shl.res", {24'b0, EX_MEM_alu_result}, 32'h03);
        check("shl.C", {31'b0, carry_flag}, 32'h1);
        ID_EX_select_c = 1'b0;
        step();
        check("shl_clr.res", {24'b0, EX_MEM_alu_result}, 32'h03);
        check("shl_clr.C", {31'b0, carry_flag}, 32'h0);

        // SHR1 0x81 with C=0 -> 0x40, C=1
        ID_EX_alu_op = 3'b111; ID_EX_select_c = 1'b1;
        step();
        check("shr.res", {24'b0, EX_MEM_alu_result}, 32'h40);
        check("shr.C", {31'b0, carry_flag}, 32'h1);

        // Logic ops; AND clears C (co=0) and sets Z
        idle_inputs();
        ID_EX_A = 8'hF0; ID_EX_B = 8'h0F; ID_EX_alu_op = 3'b010;
        ID_EX_write_c = 1'b1; ID_EX_select_c = 1'b1;
        ID_EX_write_z = 1'b1; ID_EX_select_z = 1'b1;
        step();
        check("and.res", {24'b0, EX_MEM_alu_result}, 32'h00);
        check("and.C", {31'b0, carry_flag}, 32'h0);
        check("and.Z", {31'b0, zero_flag}, 32'h1);

        idle_inputs();
        ID_EX_A = 8'h0C; ID_EX_B = 8'h30; ID_EX_alu_op = 3'b011;
        step();
        check("or.res", {24'b0, EX_MEM_alu_result}, 32'h3C);
        check("or.Z_hold", {31'b0, zero_flag}, 32'h1);

        ID_EX_A = 8'hF0; ID_EX_B = 8'hFF; ID_EX_alu_op = 3'b100;
        ID_EX_write_z = 1'b1; ID_EX_select_z = 1'b0;
        step();
        check("xor.res", {24'b0, EX_MEM_alu_result}, 32'h0F);
        check("xor.Z_clr", {31'b0, zero_flag}, 32'h0);

        idle_inputs();
        ID_EX_A = 8'h99; ID_EX_B = 8'h11; ID_EX_instruction = 19'h000A5;
        ID_EX_alu_B_mux = 1'b1; ID_EX_alu_op = 3'b101;
        step();
        check("passb.res", {24'b0, EX_MEM_alu_result}, 32'hA5);
        check("passb.store", {24'b0, EX_MEM_store_data}, 32'h11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
